// File: rtl/shift_operand_decoder_pkg.sv
// Shared definitions for the ARM operand2 decoder: shifter op codes,
// FSM state encoding and operand2 field bit positions.
package shift_operand_decoder_pkg;

  localparam logic [2:0] LSL_I = 3'b000;
  localparam logic [2:0] LSL_R = 3'b001;
  localparam logic [2:0] LSR_I = 3'b010;
  localparam logic [2:0] LSR_R = 3'b011;
  localparam logic [2:0] ASR_I = 3'b100;
  localparam logic [2:0] ASR_R = 3'b101;
  localparam logic [2:0] ROR_I = 3'b110;  // also RRX when the amount is 0
  localparam logic [2:0] ROR_R = 3'b111;

  localparam int IMM_BIT      = 25;
  localparam int REGSHIFT_BIT = 4;
  localparam int RS_LSB       = 8;
  localparam int RM_LSB       = 0;
  localparam int OP_LSB       = 4;
  localparam int SHAMT_LSB    = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_RM  = 3'd1,
    CAP_RM = 3'd2,
    CAP_RS = 3'd3,
    ISSUE  = 3'd4
  } state_t;

endpackage

// File: rtl/shift_operand_decoder_if.sv
// Bundles the decode-side handshake, register-file read port and shifter
// operand outputs of the operand2 decoder.
//
// Handshake rules (both directions): a transfer happens on a rising edge
// where valid & ready are both 1; once valid rises the sender keeps valid and
// its payload stable until that transfer; ready may change freely.
interface shift_operand_decoder_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        cpsr_c;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        sh_valid;
  logic        sh_ready;
  logic [2:0]  SHIFT_OP;
  logic [7:0]  Shift_Num;
  logic [31:0] Shift_Data;
  logic        Carry_flag;

  // Decoder side.
  modport slave (
    input  instr_valid, instr, cpsr_c, rf_rd_data, sh_ready,
    output instr_ready, rf_rd_en, rf_rd_addr, sh_valid,
           SHIFT_OP, Shift_Num, Shift_Data, Carry_flag
  );

  // Decode stage, register file and shifter side.
  modport master (
    output instr_valid, instr, cpsr_c, rf_rd_data, sh_ready,
    input  instr_ready, rf_rd_en, rf_rd_addr, sh_valid,
           SHIFT_OP, Shift_Num, Shift_Data, Carry_flag
  );
endinterface

// File: rtl/shift_operand_decoder_operand2_field_decode.sv
// Combinational split of an ARM data-processing word into the operand2
// fields the decoder FSM needs.
module operand2_field_decode
  import shift_operand_decoder_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_imm,
  output logic        is_regshift,
  output logic [3:0]  rm,
  output logic [3:0]  rs,
  output logic [2:0]  op,
  output logic [7:0]  imm_num,
  output logic [31:0] imm_data
);
  logic unused_bits;

  assign is_imm      = instr[IMM_BIT];
  assign is_regshift = !instr[IMM_BIT] && instr[REGSHIFT_BIT];
  assign rm          = instr[RM_LSB +: 4];
  assign rs          = instr[RS_LSB +: 4];
  assign op          = is_imm ? ROR_R : instr[OP_LSB +: 3];

  // Immediate rotate is encoded as half the amount in bits 11:8.
  assign imm_num  = is_imm ? {3'b000, instr[RS_LSB +: 4], 1'b0}
                           : {3'b000, instr[SHAMT_LSB +: 5]};
  assign imm_data = {24'h000000, instr[7:0]};

  assign unused_bits = ^{instr[31:26], instr[24:12]};
endmodule

// File: rtl/shift_operand_decoder.sv
// Operand2 decoder: accepts an instruction, fetches Rm/Rs through a single
// register-file read port and presents shifter operands on a valid/ready port.
module shift_operand_decoder
  import shift_operand_decoder_pkg::*;
#(
  parameter int RF_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  shift_operand_decoder_if.slave  bus,
  output state_t                  state_dbg
);
  generate
    if (RF_LAT != 1) begin : g_bad_rf_lat
      $error("shift_operand_decoder: only RF_LAT == 1 is supported");
    end
  endgenerate

  state_t      state, state_nxt;
  logic        accept;
  logic        dec_is_imm, dec_is_regshift;
  logic [3:0]  dec_rm, dec_rs;
  logic [2:0]  dec_op;
  logic [7:0]  dec_num;
  logic [31:0] dec_data;
  logic [3:0]  rm_q, rs_q;
  logic        regshift_q;
  logic [2:0]  op_q;
  logic [7:0]  num_q;
  logic [31:0] data_q;
  logic        carry_q;

  operand2_field_decode u_field_decode (
    .instr       (bus.instr),
    .is_imm      (dec_is_imm),
    .is_regshift (dec_is_regshift),
    .rm          (dec_rm),
    .rs          (dec_rs),
    .op          (dec_op),
    .imm_num     (dec_num),
    .imm_data    (dec_data)
  );

  assign bus.instr_ready = rst_n && (state == IDLE);
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign bus.sh_valid    = (state == ISSUE);
  assign bus.SHIFT_OP    = op_q;
  assign bus.Shift_Num   = num_q;
  assign bus.Shift_Data  = data_q;
  assign bus.Carry_flag  = carry_q;
  assign state_dbg       = state;

  always_comb begin
    state_nxt      = state;
    bus.rf_rd_en   = 1'b0;
    bus.rf_rd_addr = 4'd0;
    case (state)
      IDLE:   if (accept) state_nxt = dec_is_imm ? ISSUE : RD_RM;
      RD_RM: begin
        bus.rf_rd_en   = 1'b1;
        bus.rf_rd_addr = rm_q;
        state_nxt      = CAP_RM;
      end
      CAP_RM: begin
        // Rm data arrives this cycle, so the port is free to fetch Rs.
        if (regshift_q) begin
          bus.rf_rd_en   = 1'b1;
          bus.rf_rd_addr = rs_q;
          state_nxt      = CAP_RS;
        end else begin
          state_nxt = ISSUE;
        end
      end
      CAP_RS: state_nxt = ISSUE;
      ISSUE:  if (bus.sh_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand registers only move before ISSUE, which keeps them stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_q       <= 4'd0;
      rs_q       <= 4'd0;
      regshift_q <= 1'b0;
      op_q       <= 3'd0;
      num_q      <= 8'd0;
      data_q     <= 32'd0;
      carry_q    <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        rm_q       <= dec_rm;
        rs_q       <= dec_rs;
        regshift_q <= dec_is_regshift;
        op_q       <= dec_op;
        num_q      <= dec_num;
        data_q     <= dec_data;
        carry_q    <= bus.cpsr_c;
      end
      if (state == CAP_RM) data_q <= bus.rf_rd_data;
      if (state == CAP_RS) num_q  <= bus.rf_rd_data[7:0];
    end
  end
endmodule

// File: tb/tb_shift_operand_decoder.sv
// Directed bench for shift_operand_decoder: imm, reg-imm, reg-reg and RRX
// decodes, backpressure, flush and asynchronous reset mid-operation.
module tb_shift_operand_decoder;
  import shift_operand_decoder_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   flush;
  state_t state_dbg;
  int     n_cmp;
  int     n_fail;
  int     xfers;
  logic [31:0] rf_mem [16];
  logic [3:0]  rd_q [$];

  shift_operand_decoder_if bus ();

  shift_operand_decoder #(.RF_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: one-cycle read latency, plus a log of read addresses.
  always @(posedge clk) begin
    if (bus.rf_rd_en) begin
      bus.rf_rd_data <= rf_mem[bus.rf_rd_addr];
      rd_q.push_back(bus.rf_rd_addr);
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.sh_valid && bus.sh_ready && !flush) xfers++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction; returns #1 after the accept edge (cycle N+1).
  task automatic do_accept(input logic [31:0] w, input logic c);
    int guard;
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      step(1);
      guard++;
    end
    check("accept_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    bus.cpsr_c      = c;
    step(1);
    bus.instr_valid = 1'b0;
  endtask

  logic [2:0]  hold_op;
  logic [7:0]  hold_num;
  logic [31:0] hold_data;
  int          x0;

  initial begin
    n_cmp = 0; n_fail = 0; xfers = 0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'h1000_0000 + i;
    rf_mem[1] = 32'hAAAAFF00;
    rf_mem[2] = 32'h00000140;
    rst_n = 1'b0; flush = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = 32'd0; bus.cpsr_c = 1'b0;
    bus.sh_ready = 1'b1; bus.rf_rd_data = 32'd0;

    // Reset state
    step(2);
    check("rst_ready", 32'(bus.instr_ready), 32'd0);
    check("rst_sh_valid", 32'(bus.sh_valid), 32'd0);
    check("rst_rd_en", 32'(bus.rf_rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
    check("rst_op", 32'(bus.SHIFT_OP), 32'd0);
    check("rst_num", 32'(bus.Shift_Num), 32'd0);
    check("rst_data", bus.Shift_Data, 32'd0);
    check("rst_carry", 32'(bus.Carry_flag), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    step(1);

    // 1: immediate rotate, no register read
    rd_q.delete();
    do_accept(32'hE3A004FF, 1'b0);
    check("imm_valid", 32'(bus.sh_valid), 32'd1);
    check("imm_op", 32'(bus.SHIFT_OP), 32'h7);
    check("imm_num", 32'(bus.Shift_Num), 32'h08);
    check("imm_data", bus.Shift_Data, 32'h000000FF);
    check("imm_carry", 32'(bus.Carry_flag), 32'd0);
    step(1);
    check("imm_idle", 32'(state_dbg), 32'(IDLE));
    check("imm_no_reads", 32'(rd_q.size()), 32'd0);

    // 2: LSL #4 of R1
    rd_q.delete();
    do_accept(32'hE1A00201, 1'b0);
    check("lsl_rd_en_n1", 32'(bus.rf_rd_en), 32'd1);
    check("lsl_rd_addr_n1", 32'(bus.rf_rd_addr), 32'd1);
    check("lsl_valid_n1", 32'(bus.sh_valid), 32'd0);
    step(1);
    check("lsl_rd_en_n2", 32'(bus.rf_rd_en), 32'd0);
    check("lsl_valid_n2", 32'(bus.sh_valid), 32'd0);
    step(1);
    check("lsl_valid_n3", 32'(bus.sh_valid), 32'd1);
    check("lsl_op", 32'(bus.SHIFT_OP), 32'h0);
    check("lsl_num", 32'(bus.Shift_Num), 32'h04);
    check("lsl_data", bus.Shift_Data, 32'hAAAAFF00);
    step(1);
    check("lsl_idle", 32'(state_dbg), 32'(IDLE));

    // 3: ROR by R2 of R1
    rd_q.delete();
    do_accept(32'hE1A00271, 1'b0);
    check("ror_rd_addr_n1", 32'(bus.rf_rd_addr), 32'd1);
    step(1);
    check("ror_rd_en_n2", 32'(bus.rf_rd_en), 32'd1);
    check("ror_rd_addr_n2", 32'(bus.rf_rd_addr), 32'd2);
    step(1);
    check("ror_valid_n3", 32'(bus.sh_valid), 32'd0);
    check("ror_rd_en_n3", 32'(bus.rf_rd_en), 32'd0);
    step(1);
    check("ror_valid_n4", 32'(bus.sh_valid), 32'd1);
    check("ror_op", 32'(bus.SHIFT_OP), 32'h7);
    check("ror_num", 32'(bus.Shift_Num), 32'h40);
    check("ror_data", bus.Shift_Data, 32'hAAAAFF00);
    check("ror_nreads", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() == 2) begin
      check("ror_read0", 32'(rd_q[0]), 32'd1);
      check("ror_read1", 32'(rd_q[1]), 32'd2);
    end
    step(1);

    // 4: RRX, carry latched at accept
    do_accept(32'hE1A00061, 1'b1);
    bus.cpsr_c = 1'b0;
    step(2);
    check("rrx_valid", 32'(bus.sh_valid), 32'd1);
    check("rrx_op", 32'(bus.SHIFT_OP), 32'h6);
    check("rrx_num", 32'(bus.Shift_Num), 32'h00);
    check("rrx_carry", 32'(bus.Carry_flag), 32'd1);
    check("rrx_data", bus.Shift_Data, 32'hAAAAFF00);
    step(1);

    // 5: backpressure on case 2
    bus.sh_ready = 1'b0;
    do_accept(32'hE1A00201, 1'b1);
    step(2);
    check("bp_valid", 32'(bus.sh_valid), 32'd1);
    hold_op = 3'h0; hold_num = 8'h04; hold_data = 32'hAAAAFF00;
    x0 = xfers;
    bus.instr_valid = 1'b1; bus.instr = 32'hE3A004FF;
    for (int i = 0; i < 5; i++) begin
      check("bp_op", 32'(bus.SHIFT_OP), 32'(hold_op));
      check("bp_num", 32'(bus.Shift_Num), 32'(hold_num));
      check("bp_data", bus.Shift_Data, hold_data);
      check("bp_carry", 32'(bus.Carry_flag), 32'd1);
      check("bp_ready", 32'(bus.instr_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.sh_valid), 32'd1);
      step(1);
    end
    bus.instr_valid = 1'b0;
    bus.sh_ready = 1'b1;
    step(1);
    check("bp_one_xfer", 32'(xfers - x0), 32'd1);
    check("bp_idle", 32'(state_dbg), 32'(IDLE));
    check("bp_valid_low", 32'(bus.sh_valid), 32'd0);

    // 6a: flush in CAP_RS
    x0 = xfers;
    do_accept(32'hE1A00271, 1'b0);
    step(2);
    check("fl_in_cap_rs", 32'(state_dbg), 32'(CAP_RS));
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("fl_idle", 32'(state_dbg), 32'(IDLE));
    check("fl_valid", 32'(bus.sh_valid), 32'd0);
    check("fl_rd_en", 32'(bus.rf_rd_en), 32'd0);
    step(3);
    check("fl_no_xfer", 32'(xfers - x0), 32'd0);
    do_accept(32'hE3A004FF, 1'b0);
    check("fl_next_op", 32'(bus.SHIFT_OP), 32'h7);
    check("fl_next_num", 32'(bus.Shift_Num), 32'h08);
    check("fl_next_data", bus.Shift_Data, 32'h000000FF);
    step(1);

    // flush concurrent with accept drops the instruction
    bus.instr_valid = 1'b1; bus.instr = 32'hE1A00201; flush = 1'b1;
    step(1);
    bus.instr_valid = 1'b0; flush = 1'b0;
    check("flacc_idle", 32'(state_dbg), 32'(IDLE));
    check("flacc_rd_en", 32'(bus.rf_rd_en), 32'd0);

    // 6b: reset while in ISSUE
    bus.sh_ready = 1'b0;
    do_accept(32'hE3A004FF, 1'b0);
    check("rs_in_issue", 32'(state_dbg), 32'(ISSUE));
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", 32'(bus.sh_valid), 32'd0);
    check("rs_ready", 32'(bus.instr_ready), 32'd0);
    check("rs_state", 32'(state_dbg), 32'(IDLE));
    check("rs_op", 32'(bus.SHIFT_OP), 32'd0);
    check("rs_data", bus.Shift_Data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sh_ready = 1'b1;
    step(1);
    do_accept(32'hE1A00201, 1'b0);
    step(2);
    check("rs_next_valid", 32'(bus.sh_valid), 32'd1);
    check("rs_next_num", 32'(bus.Shift_Num), 32'h04);
    check("rs_next_data", bus.Shift_Data, 32'hAAAAFF00);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
